// File: rtl/xc_aesmix_pkg.sv
// xc_aesmix_pkg: shared FSM state type, operand width and GF(2^8) helpers
// for the xc_aesmix MixColumns unit and the xc_aesmix_arb arbiter.
package xc_aesmix_pkg;

   localparam int OP_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } xc_state_e;

   // Multiply by x in GF(2^8) with the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant (covers 1,2,3 and 9,b,d,e).
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] a2;
      logic [7:0] a4;
      logic [7:0] a8;
      a2 = xtime(a);
      a4 = xtime(a2);
      a8 = xtime(a4);
      return ({8{k[0]}} & a) ^ ({8{k[1]}} & a2) ^ ({8{k[2]}} & a4) ^ ({8{k[3]}} & a8);
   endfunction

   // Circulant coefficient for a byte at distance idx from the output row.
   function automatic logic [3:0] coef(input logic [1:0] idx, input logic enc);
      logic [3:0] k;
      case (idx)
         2'd0:    k = enc ? 4'h2 : 4'he;
         2'd1:    k = enc ? 4'h3 : 4'hb;
         2'd2:    k = enc ? 4'h1 : 4'hd;
         default: k = enc ? 4'h1 : 4'h9;
      endcase
      return k;
   endfunction

   // One output byte of (Inv)MixColumns; col byte 0 is the low byte.
   function automatic logic [7:0] mix_row(input logic [31:0] col, input logic [1:0] row,
                                          input logic enc);
      logic [7:0] acc;
      acc = '0;
      for (int j = 0; j < 4; j++) begin
         acc = acc ^ gmul(col[8*j +: 8], coef(2'(j) - row, enc));
      end
      return acc;
   endfunction

endpackage

// File: rtl/xc_aesmix.sv
// xc_aesmix: single-column AES (Inv)MixColumns unit.
// Column = {rs2[31:16], rs1[15:0]}, byte 0 in rs1[7:0].
// FAST = 1 computes all four bytes in one cycle; FAST = 0 shares logic for
// two bytes and takes two cycles. ready stays high until flush.
// valid must be held until ready; flush (or reset) clears the unit.
module xc_aesmix
   import xc_aesmix_pkg::*;
#(
   parameter logic FAST = 1'b1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            valid,
   input  logic [OP_W-1:0] rs1,
   input  logic [OP_W-1:0] rs2,
   input  logic            enc,
   input  logic            flush,
   output logic            ready,
   output logic [OP_W-1:0] result
);

   logic [31:0] col;
   logic        done_q;
   logic        unused_bits;

   assign col         = {rs2[31:16], rs1[15:0]};
   assign unused_bits = ^{rs1[31:16], rs2[15:0]};
   assign ready       = done_q;

   generate
      if (FAST) begin : g_fast
         // Whole column in one step.
         always_ff @(posedge clock) begin
            if (reset || flush) begin
               done_q <= 1'b0;
               result <= '0;
            end else if (valid && !done_q) begin
               done_q <= 1'b1;
               result <= {mix_row(col, 2'd3, enc), mix_row(col, 2'd2, enc),
                          mix_row(col, 2'd1, enc), mix_row(col, 2'd0, enc)};
            end
         end
      end else begin : g_area
         logic       step_q;
         logic [1:0] row_lo;
         logic [1:0] row_hi;
         logic [15:0] half;

         assign row_lo = {step_q, 1'b0};
         assign row_hi = {step_q, 1'b1};
         assign half   = {mix_row(col, row_hi, enc), mix_row(col, row_lo, enc)};

         // Low byte pair on the first step, high pair on the second.
         always_ff @(posedge clock) begin
            if (reset || flush) begin
               done_q <= 1'b0;
               step_q <= 1'b0;
               result <= '0;
            end else if (valid && !done_q) begin
               if (step_q) begin
                  result[31:16] <= half;
                  done_q        <= 1'b1;
                  step_q        <= 1'b0;
               end else begin
                  result[15:0] <= half;
                  step_q       <= 1'b1;
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/xc_aesmix_arb.sv
// xc_aesmix_arb: round-robin sharing of one xc_aesmix unit by two requesters.
// Optional build macro XC_AESMIX_ARB_RESULT_REG_EN registers the result and
// delivers it from a DONE state one cycle later.
// Handshake: a requester raises reqN_valid and holds valid/rs1/rs2/enc stable
// until reqN_ready pulses for one cycle with reqN_result; dropping valid while
// granted aborts the op with no ready pulse. state is a debug view of the FSM.
module xc_aesmix_arb
   import xc_aesmix_pkg::*;
#(
   parameter logic FAST = 1'b1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req0_valid,
   input  logic [OP_W-1:0] req0_rs1,
   input  logic [OP_W-1:0] req0_rs2,
   input  logic            req0_enc,
   output logic            req0_ready,
   output logic [OP_W-1:0] req0_result,
   input  logic            req1_valid,
   input  logic [OP_W-1:0] req1_rs1,
   input  logic [OP_W-1:0] req1_rs2,
   input  logic            req1_enc,
   output logic            req1_ready,
   output logic [OP_W-1:0] req1_result,
   output logic            gnt,
   output logic            busy,
   output logic [1:0]      state
);

   xc_state_e       state_q, state_d;
   logic            last_q, gnt_q, op_enc;
   logic [OP_W-1:0] op_rs1, op_rs2;
   logic            take, winner, done_op, own_valid;
   logic            deliver;
   logic [OP_W-1:0] deliver_data;
   logic            unit_valid, unit_flush, unit_ready;
   logic [OP_W-1:0] unit_result;
`ifdef XC_AESMIX_ARB_RESULT_REG_EN
   logic            capture;
   logic [OP_W-1:0] res_q;
`endif

   assign own_valid = gnt_q ? req1_valid : req0_valid;

   xc_aesmix #(.FAST(FAST)) u_mix (
      .clock  (clock),
      .reset  (!reset),
      .valid  (unit_valid),
      .rs1    (op_rs1),
      .rs2    (op_rs2),
      .enc    (op_enc),
      .flush  (unit_flush),
      .ready  (unit_ready),
      .result (unit_result)
   );

   // Next state, unit control and result delivery; everything idles in reset.
   always_comb begin
      state_d      = state_q;
      take         = 1'b0;
      winner       = 1'b0;
      done_op      = 1'b0;
      unit_valid   = 1'b0;
      unit_flush   = 1'b0;
      deliver      = 1'b0;
      deliver_data = '0;
`ifdef XC_AESMIX_ARB_RESULT_REG_EN
      capture      = 1'b0;
`endif
      if (reset) begin
         case (state_q)
            IDLE: begin
               if (req0_valid || req1_valid) begin
                  take    = 1'b1;
                  winner  = (req0_valid && req1_valid) ? !last_q : req1_valid;
                  state_d = BUSY;
               end
            end
            BUSY: begin
               unit_valid = 1'b1;
               if (!own_valid) begin
                  unit_flush = 1'b1;
                  done_op    = 1'b1;
                  state_d    = IDLE;
               end else if (unit_ready) begin
                  unit_flush = 1'b1;
`ifdef XC_AESMIX_ARB_RESULT_REG_EN
                  capture    = 1'b1;
                  state_d    = DONE;
`else
                  done_op      = 1'b1;
                  deliver      = 1'b1;
                  deliver_data = unit_result;
                  state_d      = IDLE;
`endif
               end
            end
`ifdef XC_AESMIX_ARB_RESULT_REG_EN
            DONE: begin
               done_op      = 1'b1;
               deliver      = 1'b1;
               deliver_data = res_q;
               state_d      = IDLE;
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM state, round-robin pointer, grant and operand latches.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         op_rs1  <= '0;
         op_rs2  <= '0;
         op_enc  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (take) begin
            gnt_q  <= winner;
            op_rs1 <= winner ? req1_rs1 : req0_rs1;
            op_rs2 <= winner ? req1_rs2 : req0_rs2;
            op_enc <= winner ? req1_enc : req0_enc;
         end
         if (done_op) begin
            last_q <= gnt_q;
         end
      end
   end

`ifdef XC_AESMIX_ARB_RESULT_REG_EN
   // Result holding register for the DONE cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         res_q <= '0;
      end else if (capture) begin
         res_q <= unit_result;
      end
   end
`endif

   assign req0_ready  = deliver && !gnt_q;
   assign req1_ready  = deliver && gnt_q;
   assign req0_result = {OP_W{req0_ready}} & deliver_data;
   assign req1_result = {OP_W{req1_ready}} & deliver_data;
   assign busy        = reset && (state_q != IDLE);
   assign gnt         = busy && gnt_q;
   assign state       = reset ? state_q : IDLE;

endmodule

// File: tb/tb_xc_aesmix_arb.sv
// tb_xc_aesmix_arb: self-checking bench for xc_aesmix_arb (both FAST values,
// with or without XC_AESMIX_ARB_RESULT_REG_EN).
module tb_xc_aesmix_arb #(
  parameter logic FAST = 1'b1
);

`ifdef XC_AESMIX_ARB_RESULT_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT = 1 + (FAST ? 1 : 2) + EXTRA;

  localparam logic [7:0] ENC_M [16] = '{8'h02, 8'h03, 8'h01, 8'h01,
                                        8'h01, 8'h02, 8'h03, 8'h01,
                                        8'h01, 8'h01, 8'h02, 8'h03,
                                        8'h03, 8'h01, 8'h01, 8'h02};
  localparam logic [7:0] DEC_M [16] = '{8'h0e, 8'h0b, 8'h0d, 8'h09,
                                        8'h09, 8'h0e, 8'h0b, 8'h0d,
                                        8'h0d, 8'h09, 8'h0e, 8'h0b,
                                        8'h0b, 8'h0d, 8'h09, 8'h0e};

  // ---------------- clock / reset / DUT ----------------
  logic        clock;
  logic        reset;
  logic        req0_valid, req0_enc, req0_ready;
  logic [31:0] req0_rs1, req0_rs2, req0_result;
  logic        req1_valid, req1_enc, req1_ready;
  logic [31:0] req1_rs1, req1_rs2, req1_result;
  logic        gnt, busy;
  logic [1:0]  state;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  xc_aesmix_arb #(.FAST(FAST)) dut (
    .clock       (clock),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_rs1    (req0_rs1),
    .req0_rs2    (req0_rs2),
    .req0_enc    (req0_enc),
    .req0_ready  (req0_ready),
    .req0_result (req0_result),
    .req1_valid  (req1_valid),
    .req1_rs1    (req1_rs1),
    .req1_rs2    (req1_rs2),
    .req1_enc    (req1_enc),
    .req1_ready  (req1_ready),
    .req1_result (req1_result),
    .gnt         (gnt),
    .busy        (busy),
    .state       (state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          flush_cnt = 0;
  logic [32:0] exp_q[$];   // {requester, result}
  logic [32:0] mon_e;

  typedef struct {
    logic        who;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[10];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Golden model: bitwise GF(2^8) product and explicit coefficient matrices.
  function automatic logic [7:0] gf_mult(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] rs1, input logic [31:0] rs2, input logic enc);
    logic [7:0]  b [4];
    logic [7:0]  r;
    logic [31:0] out;
    b[0] = rs1[7:0];
    b[1] = rs1[15:8];
    b[2] = rs2[23:16];
    b[3] = rs2[31:24];
    out = '0;
    for (int row = 0; row < 4; row++) begin
      r = 8'h00;
      for (int c = 0; c < 4; c++) begin
        r = r ^ gf_mult(enc ? ENC_M[row*4+c] : DEC_M[row*4+c], b[c]);
      end
      out[row*8 +: 8] = r;
    end
    return out;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    check("dual_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
    check("ready_in_idle", {31'd0, (req0_ready | req1_ready) & (state == 2'd0)}, 32'd0);
    check("flush_in_idle", {31'd0, dut.unit_flush & (state == 2'd0)}, 32'd0);
    check("mask0", req0_ready ? 32'd0 : req0_result, 32'd0);
    check("mask1", req1_ready ? 32'd0 : req1_result, 32'd0);
    if (dut.unit_flush) flush_cnt++;
    if (req0_ready || req1_ready) begin
      check("unexpected_ready", exp_q.size(), exp_q.size() == 0 ? 32'd1 : exp_q.size());
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("ready_who", {31'd0, req1_ready}, {31'd0, mon_e[32]});
        check("result", req1_ready ? req1_result : req0_result, mon_e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic who, input logic v, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic enc);
    if (who) begin
      req1_valid = v; req1_rs1 = rs1; req1_rs2 = rs2; req1_enc = enc;
    end else begin
      req0_valid = v; req0_rs1 = rs1; req0_rs2 = rs2; req0_enc = enc;
    end
  endtask

  // One request on an idle unit; checks latency, scoreboard checks the data.
  task automatic run_single(input string name, input logic who, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic enc, input logic [31:0] exp);
    int n;
    bit seen;
    exp_q.push_back({who, exp});
    @(posedge clock); #1;
    drive(who, 1'b1, rs1, rs2, enc);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clock);
      if (who ? req1_ready : req0_ready) seen = 1'b1;
      else n++;
    end
    check({name, "_seen"}, {31'd0, seen}, 32'd1);
    if (seen) check({name, "_latency"}, n, LAT);
    @(posedge clock); #1;
    drive(who, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  // Hold a request until its ready pulse, then release it.
  task automatic wait_drop(input string name, input logic who, input int budget);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clock);
      if (who ? req1_ready : req0_ready) seen = 1'b1;
      else n++;
    end
    check({name, "_seen"}, {31'd0, seen}, 32'd1);
    @(posedge clock); #1;
    drive(who, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int base;
    int n;
    int cnt;
    logic        rw;
    logic        re;
    logic [31:0] r1;
    logic [31:0] r2;

    tbl[0] = '{1'b0, 32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e};
    tbl[1] = '{1'b1, 32'h00004d8e, 32'hbca10000, 1'b0, 32'h455313db};
    tbl[2] = '{1'b0, 32'hffffd4d4, 32'hd5d4ffff, 1'b1, 32'hd6d7d5d5};
    tbl[3] = '{1'b1, 32'h1234d5d5, 32'hd6d75678, 1'b0, 32'hd5d4d4d4};
    tbl[4] = '{1'b1, 32'ha5a50af2, 32'h5c225a5a, 1'b1, 32'h9d58dc9f};
    tbl[5] = '{1'b0, 32'h0000dc9f, 32'h9d580000, 1'b0, 32'h5c220af2};
    tbl[6] = '{1'b0, 32'h0000262d, 32'h4c310000, 1'b1, 32'hf8bd7e4d};
    tbl[7] = '{1'b1, 32'h00007e4d, 32'hf8bd0000, 1'b0, 32'h4c31262d};
    tbl[8] = '{1'b0, 32'h00000101, 32'h01010000, 1'b0, 32'h01010101};
    tbl[9] = '{1'b1, 32'hdead0000, 32'h0000beef, 1'b1, 32'h00000000};

    reset = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clock);

    // Reset state, then with both requests pending during reset.
    @(negedge clock);
    check("rst_state", state, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_gnt", {31'd0, gnt}, 32'd0);
    @(posedge clock); #1;
    exp_q.push_back({1'b0, tbl[0].exp});
    exp_q.push_back({1'b1, tbl[1].exp});
    drive(1'b0, 1'b1, tbl[0].rs1, tbl[0].rs2, tbl[0].enc);
    drive(1'b1, 1'b1, tbl[1].rs1, tbl[1].rs2, tbl[1].enc);
    @(negedge clock);
    check("rst_req_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {30'd0, req1_ready, req0_ready}, 32'd0);

    // Both valid from the reset release cycle: req0 then req1.
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("rel_idle", state, 32'd0);
    @(negedge clock);
    check("rel_busy", {31'd0, busy}, 32'd1);
    check("rel_gnt0", {31'd0, gnt}, 32'd0);
    fork
      wait_drop("both_r0", 1'b0, 20);
      wait_drop("both_r1", 1'b1, 40);
    join

    // Single-requester vectors.
    run_single("vec1", 1'b0, tbl[0].rs1, tbl[0].rs2, tbl[0].enc, tbl[0].exp);
    run_single("vec2", 1'b1, tbl[1].rs1, tbl[1].rs2, tbl[1].enc, tbl[1].exp);

    // Both held for six ops: strict alternation starting with req0.
    base = flush_cnt;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({(i % 2) == 1, (i % 2) == 1 ? tbl[1].exp : tbl[0].exp});
    end
    @(posedge clock); #1;
    drive(1'b0, 1'b1, tbl[0].rs1, tbl[0].rs2, tbl[0].enc);
    drive(1'b1, 1'b1, tbl[1].rs1, tbl[1].rs2, tbl[1].enc);
    n = 0;
    cnt = 0;
    while (cnt < 6 && n < 200) begin
      @(negedge clock);
      if (req0_ready || req1_ready) cnt++;
      n++;
    end
    check("alt_count", cnt, 32'd6);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clock);
    check("alt_flush", flush_cnt - base, 32'd6);

    // Table of known-answer vectors.
    for (int i = 0; i < 10; i++) begin
      run_single($sformatf("tbl%0d", i), tbl[i].who, tbl[i].rs1, tbl[i].rs2, tbl[i].enc, tbl[i].exp);
    end

    // Random operands against the golden model.
    for (int i = 0; i < 8; i++) begin
      rw = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      r1 = $urandom();
      r2 = $urandom();
      run_single($sformatf("rnd%0d", i), rw, r1, r2, re, golden(r1, r2, re));
    end

    // Abort: req0 drops valid the cycle after grant.
    base = flush_cnt;
    @(posedge clock); #1;
    drive(1'b0, 1'b1, tbl[0].rs1, tbl[0].rs2, tbl[0].enc);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    @(negedge clock);
    check("abort_flush", {31'd0, dut.unit_flush}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd1);
    check("abort_ready", {31'd0, req0_ready}, 32'd0);
    @(negedge clock);
    check("abort_idle", {31'd0, busy}, 32'd0);
    check("abort_flush_once", flush_cnt - base, 32'd1);
    run_single("after_abort", 1'b1, tbl[1].rs1, tbl[1].rs2, tbl[1].enc, tbl[1].exp);

    // Reset while BUSY.
    @(posedge clock); #1;
    drive(1'b0, 1'b1, tbl[0].rs1, tbl[0].rs2, tbl[0].enc);
    @(posedge clock); #1;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clock);
    check("mid_rst_out", {28'd0, busy, gnt, req0_ready, req1_ready}, 32'd0);
    check("mid_rst_flush", {31'd0, dut.unit_flush}, 32'd0);
    check("mid_rst_res", req0_result | req1_result, 32'd0);
    @(negedge clock);
    check("post_rst_state", state, 32'd0);
    check("post_rst_out", {28'd0, busy, gnt, req0_ready, req1_ready}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    run_single("after_rst", 1'b0, tbl[0].rs1, tbl[0].rs2, tbl[0].enc, tbl[0].exp);

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
